// File: rtl/acc_segment_exec.sv
//------------------------------------------------------------------------------
// Module   : acc_segment_exec
// Purpose  : Segment FIFO and sequencer feeding acc_profile_gen; optional
//            seg_count output enabled by ACC_SEG_EXEC_SEG_COUNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acc_segment_exec #(
  parameter int DEPTH_W = 2,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DIV_W-1:0]   tick_div,
  input  logic               wr_en,
  input  logic [191:0]       wr_data,
  input  logic [5:0]         wr_flags,
  output logic               fifo_full,
  output logic [DEPTH_W:0]   fifo_count,
  input  logic               start,
  input  logic               stop,
  input  logic               clear_err,
  input  logic               gen_stopped,
  output logic               acc_step,
  output logic               load,
  output logic               set_v,
  output logic               set_a,
  output logic               set_j,
  output logic               set_jj,
  output logic               set_target_v,
  output logic [31:0]        v_val,
  output logic [31:0]        a_val,
  output logic [31:0]        j_val,
  output logic [31:0]        jj_val,
  output logic [31:0]        target_v_val,
  output logic               abort,
  output logic               busy,
  output logic               seg_done,
  output logic               underflow,
  output logic               overflow,
`ifdef ACC_SEG_EXEC_SEG_COUNT_EN
  output logic [31:0]        seg_count,
`endif
  output logic [31:0]        remaining
);

  localparam int             c_DEPTH   = 1 << DEPTH_W;
  localparam int             c_ENTRY_W = 198;
  localparam logic [DEPTH_W:0] c_FULL  = (DEPTH_W+1)'(c_DEPTH);
  localparam logic [DEPTH_W:0] c_ONE   = (DEPTH_W+1)'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;
  localparam logic [1:0] c_ABORT = 2'd3;

  logic [c_ENTRY_W-1:0] r_mem [c_DEPTH];
  logic [DEPTH_W-1:0]   r_wr_ptr;
  logic [DEPTH_W-1:0]   r_rd_ptr;
  logic [DEPTH_W:0]     r_count;
  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [31:0]          r_remaining;
  logic                 r_last;
  logic                 r_underflow;
  logic                 r_overflow;

  logic [c_ENTRY_W-1:0] w_head;
  logic [31:0]          w_head_dur;
  logic                 w_full;
  logic                 w_push;
  logic                 w_wr_ovf;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_in_load;
  logic                 w_ticking;
  logic                 w_seg_end;
  logic                 w_more;
  logic                 w_last_eff;
  logic                 w_underflow_evt;

  // Entry layout: {dur, v, a, j, jj, target_v, last, set_target_v, set_jj, set_j, set_a, set_v}
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_dur = w_head[197:166];
  assign w_full     = (r_count == c_FULL);
  assign w_push     = wr_en && !w_full;
  assign w_wr_ovf   = wr_en && w_full;
  assign w_in_load  = (r_state == c_LOAD);
  assign w_pop      = w_in_load;
  assign w_ticking  = ((r_state == c_RUN) || (r_state == c_ABORT)) && (r_div_cnt == tick_div);
  assign w_seg_end  = (w_in_load && (w_head_dur == 32'd0)) ||
                      ((r_state == c_RUN) && w_ticking && (r_remaining == 32'd1));
  // In LOAD the head is still counted but is being consumed this cycle.
  assign w_more     = w_in_load ? (r_count > c_ONE) : (r_count != '0);
  assign w_last_eff = w_in_load ? w_head[5] : r_last;
  assign w_flush    = (w_next_state == c_ABORT) && (r_state != c_ABORT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_underflow_evt = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (start && (r_count != '0)) w_next_state = c_LOAD;
      end
      c_LOAD, c_RUN: begin
        if (stop) begin
          w_next_state = c_ABORT;
        end else if (w_seg_end) begin
          if (w_more) begin
            w_next_state = c_LOAD;
          end else if (w_last_eff) begin
            w_next_state = c_IDLE;
          end else begin
            w_underflow_evt = 1'b1;
            w_next_state    = c_ABORT;
          end
        end else if (w_in_load) begin
          w_next_state = c_RUN;
        end
      end
      c_ABORT: begin
        if (gen_stopped && !w_ticking) w_next_state = c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    load         = 1'b0;
    set_v        = 1'b0;
    set_a        = 1'b0;
    set_j        = 1'b0;
    set_jj       = 1'b0;
    set_target_v = 1'b0;
    v_val        = '0;
    a_val        = '0;
    j_val        = '0;
    jj_val       = '0;
    target_v_val = '0;
    busy         = (r_state != c_IDLE);
    abort        = (r_state == c_ABORT);
    acc_step     = w_ticking;
    seg_done     = w_seg_end;
    if (w_in_load) begin
      load         = 1'b1;
      set_v        = w_head[0];
      set_a        = w_head[1];
      set_j        = w_head[2];
      set_jj       = w_head[3];
      set_target_v = w_head[4];
      v_val        = w_head[165:134];
      a_val        = w_head[133:102];
      j_val        = w_head[101:70];
      jj_val       = w_head[69:38];
      target_v_val = w_head[37:6];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr_data, wr_flags};
  end

  // A push coinciding with the abort flush survives as the new head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= {DEPTH_W'(0), w_push};
      end else begin
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + (DEPTH_W+1)'(w_push) - (DEPTH_W+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt   <= '0;
      r_remaining <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        c_LOAD: begin
          r_remaining <= w_head_dur;
          r_div_cnt   <= '0;
          r_last      <= w_head[5];
        end
        c_RUN, c_ABORT: begin
          if (w_ticking) begin
            r_div_cnt <= '0;
            if (r_state == c_RUN) r_remaining <= r_remaining - 32'd1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_div_cnt <= '0;
      endcase
      if (w_next_state == c_IDLE) r_div_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_underflow_evt)  r_underflow <= 1'b1;
      else if (clear_err)   r_underflow <= 1'b0;
      if (w_wr_ovf)         r_overflow  <= 1'b1;
      else if (clear_err)   r_overflow  <= 1'b0;
    end
  end

`ifdef ACC_SEG_EXEC_SEG_COUNT_EN
  logic [31:0] r_seg_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_count <= '0;
    end else if (w_seg_end) begin
      r_seg_count <= r_seg_count + 32'd1;
    end
  end

  assign seg_count = r_seg_count;
`endif

  assign fifo_full  = w_full;
  assign fifo_count = r_count;
  assign underflow  = r_underflow;
  assign overflow   = r_overflow;
  assign remaining  = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_acc_segment_exec.sv
//------------------------------------------------------------------------------
// Module   : tb_acc_segment_exec
// Purpose  : Directed self-checking bench for acc_segment_exec with a load scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acc_segment_exec;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  tick_div;
  logic         wr_en;
  logic [191:0] wr_data;
  logic [5:0]   wr_flags;
  logic         fifo_full;
  logic [2:0]   fifo_count;
  logic         start, stop, clear_err, gen_stopped;
  logic         acc_step, load;
  logic         set_v, set_a, set_j, set_jj, set_target_v;
  logic [31:0]  v_val, a_val, j_val, jj_val, target_v_val;
  logic         abort, busy, seg_done, underflow, overflow;
  logic [31:0]  remaining;
`ifdef ACC_SEG_EXEC_SEG_COUNT_EN
  logic [31:0]  seg_count;
`endif

  int checks = 0;
  int errors = 0;
  int n_load = 0;
  logic [164:0] exp_q [$];

  always #5 clk = ~clk;

  acc_segment_exec #(.DEPTH_W(2), .DIV_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .tick_div(tick_div),
    .wr_en(wr_en), .wr_data(wr_data), .wr_flags(wr_flags),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .start(start), .stop(stop), .clear_err(clear_err), .gen_stopped(gen_stopped),
    .acc_step(acc_step), .load(load),
    .set_v(set_v), .set_a(set_a), .set_j(set_j), .set_jj(set_jj), .set_target_v(set_target_v),
    .v_val(v_val), .a_val(a_val), .j_val(j_val), .jj_val(jj_val), .target_v_val(target_v_val),
    .abort(abort), .busy(busy), .seg_done(seg_done),
    .underflow(underflow), .overflow(overflow),
`ifdef ACC_SEG_EXEC_SEG_COUNT_EN
    .seg_count(seg_count),
`endif
    .remaining(remaining)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_seg(input logic [31:0] dur, v, a, j, jj, tv,
                          input logic [5:0] fl, input bit expect_load);
    #1;
    wr_en    = 1'b1;
    wr_data  = {dur, v, a, j, jj, tv};
    wr_flags = fl;
    if (expect_load) exp_q.push_back({fl[4:0], v, a, j, jj, tv});
    @(negedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic record(input int n, output logic [31:0] ld, st, sd, rem1);
    ld = '0; st = '0; sd = '0; rem1 = '0;
    for (int i = 0; i < n; i++) begin
      ld[i] = load;
      st[i] = acc_step;
      sd[i] = seg_done;
      if (i == 1) rem1 = remaining;
      @(negedge clk);
    end
  endtask

  // Scoreboard: every load must match the oldest expected segment.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("load_with_step", {63'd0, load & acc_step}, 64'd0);
      if (load) begin
        n_load++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL load_unexpected: observed load=1 expected no load");
        end
        if (exp_q.size() != 0) begin
          logic [164:0] e, o;
          e = exp_q.pop_front();
          o = {set_target_v, set_jj, set_j, set_a, set_v, v_val, a_val, j_val, jj_val, target_v_val};
          checks++;
          assert (o === e) else begin
            errors++;
            $error("FAIL load_record: observed %0h expected %0h", o, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish within 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ld, st, sd, rem1;
    int saved_load;
    reset_n = 1'b0; tick_div = '0; wr_en = 1'b0; wr_data = '0; wr_flags = '0;
    start = 1'b0; stop = 1'b0; clear_err = 1'b0; gen_stopped = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_step", acc_step, 0);
    chk("rst_abort", abort, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_flags", {underflow, overflow}, 0);
    #1 reset_n = 1'b1;

    // Two back-to-back segments, single-clock tick rate
    push_seg(32'd3, 32'h100, 32'h10, 32'h7, 32'h8, 32'h9, 6'b000011, 1'b1);
    push_seg(32'd3, 32'h200, 32'h0, 32'h1, 32'h2, 32'h3, 6'b100010, 1'b1);
    chk("t1_count", fifo_count, 2);
    pulse_start();
    record(8, ld, st, sd, rem1);
    chk("t1_load", ld, 32'h11);
    chk("t1_step", st, 32'hEE);
    chk("t1_segdone", sd, 32'h88);
    chk("t1_rem", rem1, 3);
    chk("t1_busy", busy, 0);
    chk("t1_underflow", underflow, 0);
    chk("t1_qdrain", exp_q.size(), 0);

    // Non-last segment runs dry -> underflow and abort handshake
    #1 tick_div = 16'd4;
    push_seg(32'd2, 32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 6'b000000, 1'b1);
    pulse_start();
    record(11, ld, st, sd, rem1);
    chk("t2_load", ld, 32'h1);
    chk("t2_step", st, 32'h420);
    chk("t2_segdone", sd, 32'h400);
    chk("t2_abort", abort, 1);
    chk("t2_underflow", underflow, 1);
    repeat (4) @(negedge clk);
    chk("t2_abort_step", acc_step, 1);
    #1 gen_stopped = 1'b1;
    @(negedge clk);
    chk("t2_hold_on_tick", abort, 1);
    @(negedge clk);
    chk("t2_exit_abort", abort, 0);
    chk("t2_exit_busy", busy, 0);
    #1 gen_stopped = 1'b0; clear_err = 1'b1;
    @(negedge clk);
    #1 clear_err = 1'b0;
    chk("t2_clear", underflow, 0);

    // Fill FIFO then overflow
    #1 tick_div = 16'd0;
    push_seg(32'd1, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 6'b000100, 1'b1);
    push_seg(32'd4, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 6'b011000, 1'b1);
    push_seg(32'd9, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 6'b000001, 1'b1);
    push_seg(32'd9, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 6'b100001, 1'b1);
    chk("t3_full", fifo_full, 1);
    chk("t3_count4", fifo_count, 4);
    push_seg(32'd5, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 6'b100000, 1'b0);
    chk("t3_count_hold", fifo_count, 4);
    chk("t3_overflow", overflow, 1);
    #1 clear_err = 1'b1;
    @(negedge clk);
    #1 clear_err = 1'b0;
    chk("t3_clear", overflow, 0);

    // Stop mid-RUN with two entries still queued
    pulse_start();
    repeat (4) @(negedge clk);
    chk("t4_rem", remaining, 3);
    chk("t4_count", fifo_count, 2);
    chk("t4_step", acc_step, 1);
    #1 stop = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    saved_load = n_load;
    @(negedge clk);
    #1 stop = 1'b0;
    chk("t4_abort", abort, 1);
    chk("t4_flush", fifo_count, 0);
    tick_div = 16'd1; gen_stopped = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("t4_idle", busy, 0);
    chk("t4_no_load", n_load - saved_load, 0);
    #1 gen_stopped = 1'b0; tick_div = 16'd0;

    // Zero-duration segment followed by a one-tick segment
    push_seg(32'd0, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 6'b000010, 1'b1);
    push_seg(32'd1, 32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 6'b110000, 1'b1);
    pulse_start();
    record(4, ld, st, sd, rem1);
    chk("t5_load", ld, 32'h3);
    chk("t5_step", st, 32'h4);
    chk("t5_segdone", sd, 32'h5);
    chk("t5_busy", busy, 0);
    chk("t5_underflow", underflow, 0);

    // Asynchronous reset in the middle of RUN
    push_seg(32'd10, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85, 6'b100001, 1'b1);
    push_seg(32'd5, 32'h91, 32'h92, 32'h93, 32'h94, 32'h95, 6'b100001, 1'b1);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    chk("t6_count_pre", fifo_count, 1);
    void'(exp_q.pop_back());
    #1 reset_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_step", acc_step, 0);
    chk("t6_rem", remaining, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_abort", abort, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_post_abort", abort, 0);
    chk("t6_post_busy", busy, 0);
    chk("qdrain_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
